frequency_analyzer_window: RTL and testbench

- Measurement end of the analyzer start/stop protocol; consumes the start_analyzer/stop_analyzer pulses produced by frequency_analyzer_synch.
- Within each window, counts rising edges and high/low clock cycles of a single-bit input (pixel/strobe line) and latches the results.
- One instance per analyzer channel (0 and 1); results feed the downstream frequency/duty computation.

---
 rtl/frequency_analyzer_window.sv | 194 +++++++++++++++++++
 tb/tb_frequency_analyzer_window.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_analyzer_window.sv
// Window measurement for one analyzer channel: counts rising edges and high/low cycles
// between start/stop pulses. Optional watchdog abort under FREQUENCY_ANALYZER_TIMEOUT_EN.
`timescale 1ns/1ps

// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start pulse, working counters frozen
// MEASURE | window open, counting every cycle including the stop cycle
// DONE    | one cycle: publish working counters, pulse result_valid
module frequency_analyzer_window #(
    parameter int unsigned CLOCK         = 100000000,
    parameter int unsigned FREQUENCY     = 2000,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start_analyzer,
    input  logic                     stop_analyzer,
    input  logic                     signal_in,
    output logic [COUNTER_WIDTH-1:0] edge_count,
    output logic [COUNTER_WIDTH-1:0] high_time,
    output logic [COUNTER_WIDTH-1:0] low_time,
    output logic                     result_valid,
    output logic                     overflow,
    output logic                     busy,
    output logic                     timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    if (FREQUENCY == 0 || CLOCK < FREQUENCY) begin : g_bad_rate
        $error("frequency_analyzer_window: FREQUENCY must be nonzero and not exceed CLOCK");
    end

    state_t state_q, state_d;

    logic sync1, sync2, sync3;
    logic rise;

    logic [COUNTER_WIDTH-1:0] edge_cnt, high_cnt, low_cnt;
    logic                     ovf_cnt;

    logic cnt_clear, cnt_run, load_out;
    logic wd_abort;

    // sync3 lags sync2 by one cycle so the edge detector sees only settled levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_run   = 1'b0;
        load_out  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && start_analyzer && !stop_analyzer) begin
                    cnt_clear = 1'b1;
                    state_d   = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_run = 1'b1;
                    if (stop_analyzer) begin
                        state_d = S_DONE;
                    end else if (start_analyzer) begin
                        cnt_clear = 1'b1;
                    end else if (wd_abort) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                load_out = enable;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating working counters; a clear (start or restart) wins over counting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
            high_cnt <= '0;
            low_cnt  <= '0;
            ovf_cnt  <= 1'b0;
        end else if (cnt_clear) begin
            edge_cnt <= '0;
            high_cnt <= '0;
            low_cnt  <= '0;
            ovf_cnt  <= 1'b0;
        end else if (cnt_run) begin
            if (sync2) begin
                if (high_cnt == CNT_MAX) ovf_cnt <= 1'b1;
                else                     high_cnt <= high_cnt + CNT_ONE;
            end else begin
                if (low_cnt == CNT_MAX) ovf_cnt <= 1'b1;
                else                    low_cnt <= low_cnt + CNT_ONE;
            end
            if (rise) begin
                if (edge_cnt == CNT_MAX) ovf_cnt <= 1'b1;
                else                     edge_cnt <= edge_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_count   <= '0;
            high_time    <= '0;
            low_time     <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= load_out;
            if (load_out) begin
                edge_count <= edge_cnt;
                high_time  <= high_cnt;
                low_time   <= low_cnt;
                overflow   <= ovf_cnt;
            end
        end
    end

    assign busy = (state_q == S_MEASURE);

`ifdef FREQUENCY_ANALYZER_TIMEOUT_EN
    localparam int unsigned WD_LIMIT = 2 * (CLOCK / FREQUENCY);
    localparam int          WD_W     = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wd_q;

    // Down-counter reloaded on start/restart; terminal count is the last allowed MEASURE cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (cnt_clear) begin
            wd_q <= WD_LOAD;
        end else if (state_q == S_MEASURE && wd_q != '0) begin
            wd_q <= wd_q - WD_ONE;
        end
    end

    assign wd_abort = (state_q == S_MEASURE) && enable && !stop_analyzer
                      && !start_analyzer && (wd_q == WD_ONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= wd_abort;
        end
    end
`else
    assign wd_abort = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_frequency_analyzer_window.sv
// Scoreboard bench for frequency_analyzer_window: a 32-bit default instance and a
// 4-bit instance with a 20-cycle watchdog limit, checked against a window-level model.
`timescale 1ns/1ps

module tb_frequency_analyzer_window;

    localparam int HMAX = 30000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] en_v, start_v, stop_v, sig_v;

    logic [31:0] edge_a, high_a, low_a;
    logic        rv_a, ovf_a, busy_a, to_a;
    logic [3:0]  edge_b, high_b, low_b;
    logic        rv_b, ovf_b, busy_b, to_b;

    always #5 clock = ~clock;

    frequency_analyzer_window dut_a (
        .clock(clock), .reset(reset), .enable(en_v[0]),
        .start_analyzer(start_v[0]), .stop_analyzer(stop_v[0]), .signal_in(sig_v[0]),
        .edge_count(edge_a), .high_time(high_a), .low_time(low_a),
        .result_valid(rv_a), .overflow(ovf_a), .busy(busy_a), .timeout(to_a)
    );

    frequency_analyzer_window #(.CLOCK(100000000), .FREQUENCY(10000000), .COUNTER_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset), .enable(en_v[1]),
        .start_analyzer(start_v[1]), .stop_analyzer(stop_v[1]), .signal_in(sig_v[1]),
        .edge_count(edge_b), .high_time(high_b), .low_time(low_b),
        .result_valid(rv_b), .overflow(ovf_b), .busy(busy_b), .timeout(to_b)
    );

    typedef struct {
        longint ed;
        longint hi;
        longint lo;
        longint ovf;
        longint cyc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   qt[$];

    bit hist [2][HMAX];
    int cyc = 0;
    int mode [2];
    bit lvl  [2];

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Edge k of the run samples the input into hist[k]; edge 0 is the first edge out of reset
    always @(posedge clock) begin
        if (reset) begin
            if (cyc < HMAX) begin
                hist[0][cyc] = sig_v[0];
                hist[1][cyc] = sig_v[1];
            end
            cyc = cyc + 1;
        end
    end

    always @(posedge clock) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (mode[d])
                0:       sig_v[d] = lvl[d];
                1:       sig_v[d] = ((cyc % 100) < 50);
                2:       if ($urandom_range(0, 5) == 0) sig_v[d] = ~sig_v[d];
                default: sig_v[d] = ~sig_v[d];
            endcase
        end
    end

    function automatic bit h(int d, int k);
        if (k < 0 || k >= HMAX) return 1'b0;
        return hist[d][k];
    endfunction

    // Window between start edge s and stop edge e: the design sees the input two edges late
    function automatic exp_t model(int d, int s, int e, int w);
        exp_t   r;
        longint mx = (longint'(1) << w) - 1;
        longint hi = 0, lo = 0, ed = 0;
        for (int k = s + 1; k <= e; k++) begin
            if (h(d, k - 2)) hi++;
            else             lo++;
            if (h(d, k - 2) && !h(d, k - 3)) ed++;
        end
        r.ovf = ((hi > mx) || (lo > mx) || (ed > mx)) ? 1 : 0;
        r.hi  = (hi > mx) ? mx : hi;
        r.lo  = (lo > mx) ? mx : lo;
        r.ed  = (ed > mx) ? mx : ed;
        r.cyc = e + 1;
        return r;
    endfunction

    exp_t xa, xb;

    always @(negedge clock) begin
        if (reset) begin
            if (rv_a) begin
                if (qa.size() == 0) begin
                    check("pending_result_a", longint'(qa.size() > 0), 1);
                end else begin
                    xa = qa.pop_front();
                    check("edge_count_a",   longint'(edge_a), xa.ed);
                    check("high_time_a",    longint'(high_a), xa.hi);
                    check("low_time_a",     longint'(low_a),  xa.lo);
                    check("overflow_a",     longint'(ovf_a),  xa.ovf);
                    check("valid_cycle_a",  longint'(cyc - 1), xa.cyc);
                end
            end
            if (rv_b) begin
                if (qb.size() == 0) begin
                    check("pending_result_b", longint'(qb.size() > 0), 1);
                end else begin
                    xb = qb.pop_front();
                    check("edge_count_b",   longint'(edge_b), xb.ed);
                    check("high_time_b",    longint'(high_b), xb.hi);
                    check("low_time_b",     longint'(low_b),  xb.lo);
                    check("overflow_b",     longint'(ovf_b),  xb.ovf);
                    check("valid_cycle_b",  longint'(cyc - 1), xb.cyc);
                end
            end
            if (to_b) begin
                if (qt.size() == 0) check("pending_timeout_b", longint'(qt.size() > 0), 1);
                else                check("timeout_cycle_b", longint'(cyc - 1), longint'(qt.pop_front()));
            end
            if (to_a) check("timeout_a_idle", longint'(to_a), 0);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_pulse(int d, output int s);
        start_v[d] = 1'b1;
        tick(1);
        start_v[d] = 1'b0;
        s = cyc - 1;
    endtask

    task automatic stop_pulse(int d, bit with_start, output int e);
        stop_v[d]  = 1'b1;
        start_v[d] = with_start;
        tick(1);
        stop_v[d]  = 1'b0;
        start_v[d] = 1'b0;
        e = cyc - 1;
    endtask

    task automatic push_const(int d, longint ed, longint hi, longint lo, longint ovf, int e);
        exp_t x;
        x.ed = ed; x.hi = hi; x.lo = lo; x.ovf = ovf; x.cyc = e + 1;
        if (d == 0) qa.push_back(x);
        else        qb.push_back(x);
    endtask

    task automatic check_outputs(string name, int d, longint ed, longint hi, longint lo, longint ovf);
        if (d == 0) begin
            check({name, "_edge"}, longint'(edge_a), ed);
            check({name, "_high"}, longint'(high_a), hi);
            check({name, "_low"},  longint'(low_a),  lo);
            check({name, "_ovf"},  longint'(ovf_a),  ovf);
        end else begin
            check({name, "_edge"}, longint'(edge_b), ed);
            check({name, "_high"}, longint'(high_b), hi);
            check({name, "_low"},  longint'(low_b),  lo);
            check({name, "_ovf"},  longint'(ovf_b),  ovf);
        end
    endtask

    task automatic rand_window(int d, int maxlen, int w);
        int   s, e, n;
        exp_t x;
        mode[d] = 2;
        tick($urandom_range(3, 30));
        start_pulse(d, s);
        if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(0, maxlen - 1));
            start_pulse(d, s);
        end
        n = $urandom_range(1, maxlen);
        tick(n - 1);
        stop_pulse(d, ($urandom_range(0, 3) == 0), e);
        x = model(d, s, e, w);
        if (d == 0) qa.push_back(x);
        else        qb.push_back(x);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

    initial begin
        int s, e;
        en_v    = 2'b11;
        start_v = 2'b00;
        stop_v  = 2'b00;
        sig_v   = 2'b00;
        mode    = '{3, 3};
        lvl     = '{0, 1};

        // reset held with the inputs toggling
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset_a", 0, 0, 0, 0, 0);
        check_outputs("reset_b", 1, 0, 0, 0, 0);
        check("reset_flags_a", longint'({rv_a, busy_a, to_a}), 0);
        check("reset_flags_b", longint'({rv_b, busy_b, to_b}), 0);
        mode  = '{0, 0};
        reset = 1'b1;
        tick(5);
        check_outputs("idle_no_start_a", 0, 0, 0, 0, 0);
        check("idle_busy_a", longint'(busy_a), 0);

        // square wave, 100-cycle period, 1000-cycle window
        mode[0] = 1;
        tick(20);
        start_pulse(0, s);
        check("busy_square_a", longint'(busy_a), 1);
        tick(999);
        stop_pulse(0, 1'b0, e);
        push_const(0, 10, 500, 500, 0, e);
        tick(5);

        // start and stop together in IDLE, then a clean 100-cycle window held high
        mode[0] = 0;
        lvl[0]  = 1'b1;
        tick(10);
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        check("same_cycle_busy_a", longint'(busy_a), 0);
        tick(199);
        start_pulse(0, s);
        tick(99);
        stop_pulse(0, 1'b0, e);
        push_const(0, 0, 100, 0, 0, e);
        tick(4);

        // restart at +400, stop at +700, input low; a start landing in DONE is ignored
        lvl[0] = 1'b0;
        tick(10);
        start_pulse(0, s);
        tick(399);
        start_pulse(0, s);
        tick(299);
        stop_pulse(0, 1'b0, e);
        push_const(0, 0, 0, 300, 0, e);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        check("start_in_done_busy_a", longint'(busy_a), 0);
        tick(1);
        check("start_in_done_idle_a", longint'(busy_a), 0);

        // enable dropped mid-window: abort, outputs keep the previous result
        tick(5);
        start_pulse(0, s);
        tick(49);
        en_v[0] = 1'b0;
        tick(1);
        check("enable_abort_busy_a", longint'(busy_a), 0);
        tick(5);
        check_outputs("hold_after_abort_a", 0, 0, 0, 300, 0);
        en_v[0] = 1'b1;
        tick(2);

        for (int i = 0; i < 10; i++) rand_window(0, 300, 32);
        tick(5);

        // 4-bit instance: saturation, then a clean window clears overflow
        mode[1] = 0;
        lvl[1]  = 1'b1;
        tick(10);
        start_pulse(1, s);
        tick(19);
        stop_pulse(1, 1'b0, e);
        push_const(1, 0, 15, 0, 1, e);
        tick(3);
        start_pulse(1, s);
        tick(4);
        stop_pulse(1, 1'b0, e);
        push_const(1, 0, 5, 0, 0, e);
        tick(3);

        for (int i = 0; i < 10; i++) rand_window(1, 19, 4);
        tick(5);

        // open window with no stop
        mode[1] = 0;
        lvl[1]  = 1'b0;
        tick(5);
        start_pulse(1, s);
`ifdef FREQUENCY_ANALYZER_TIMEOUT_EN
        qt.push_back(s + 20);
        tick(20);
        check("timeout_busy_b", longint'(busy_b), 0);
        tick(3);
`else
        tick(30);
        check("no_timeout_busy_b", longint'(busy_b), 1);
        check("no_timeout_flag_b", longint'(to_b), 0);
        en_v[1] = 1'b0;
        tick(1);
        check("enable_abort_busy_b", longint'(busy_b), 0);
        en_v[1] = 1'b1;
        tick(2);
`endif

        // reset in the middle of a window clears everything at once
        tick(3);
        start_pulse(0, s);
        tick(30);
        reset = 1'b0;
        #1;
        check_outputs("reset_mid_window_a", 0, 0, 0, 0, 0);
        check("reset_mid_window_busy_a", longint'(busy_a), 0);

        check("results_drained_a", longint'(qa.size()), 0);
        check("results_drained_b", longint'(qb.size()), 0);
        check("timeouts_drained_b", longint'(qt.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
